// File: rtl/top_level_pkg.sv
// Shared types and constants for the message-encryption engine: FSM states,
// LFSR tap table, fixed memory map and preamble clamp helpers.
package top_level_pkg;

    typedef enum logic [2:0] {IDLE, LD_PRE, LD_TAP, LD_SEED, ENC, DONE} state_t;

    // Packed so that element k is tap pattern k; listed from index 8 down to 0.
    localparam logic [8:0][6:0] TAP_PATTERNS = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    localparam logic [7:0] MSG_BASE  = 8'd0;
    localparam logic [7:0] PRE_ADDR  = 8'd61;
    localparam logic [7:0] TAP_ADDR  = 8'd62;
    localparam logic [7:0] SEED_ADDR = 8'd63;
    localparam logic [7:0] OUT_BASE  = 8'd64;

    localparam logic [7:0] PRE_MIN = 8'd10;
    localparam logic [7:0] PRE_MAX = 8'd26;

    function automatic logic [4:0] clamp_pre(input logic [7:0] raw);
        if (raw < PRE_MIN)
            return PRE_MIN[4:0];
        else if (raw > PRE_MAX)
            return PRE_MAX[4:0];
        else
            return raw[4:0];
    endfunction

    function automatic logic [3:0] tap_index(input logic [7:0] pt_no);
        return (pt_no == 8'd8) ? 4'd8 : {1'b0, pt_no[2:0]};
    endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256x8 data memory: combinational read port, synchronous write port, no reset.
// Latency: read 0 cycles, write visible after the clock edge. No backpressure.
// The storage array name is kept as Core so the bench can reach it directly.
module data_mem (
    input  logic       clk,
    input  logic       wr_vld,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_dat,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_dat
);

    logic [7:0] Core [0:255];

    always_ff @(posedge clk) begin
        if (wr_vld)
            Core[wr_addr] <= wr_dat;
    end

    assign rd_dat = Core[rd_addr];

endmodule

// File: rtl/top_level.sv
// LFSR message encryptor: loads preamble/taps/seed, writes 64 parity-tagged bytes.
// Latency: Ack rises 68 edges after Start low is sampled in IDLE.
// Backpressure: none; Start is only looked at in IDLE and DONE.
module top_level
    import top_level_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    state_t     state;
    logic [5:0] cnt;
    logic [6:0] lfsr;
    logic [6:0] taps;
    logic [4:0] pre;

    logic [7:0] rd_addr;
    logic [7:0] rd_dat;
    logic [7:0] wr_addr;
    logic [7:0] wr_dat;
    logic       wr_vld;
    logic       pad;
    logic [7:0] plain;
    logic [6:0] enc7;

    data_mem DM (
        .clk    (Clk),
        .wr_vld (wr_vld),
        .wr_addr(wr_addr),
        .wr_dat (wr_dat),
        .rd_addr(rd_addr),
        .rd_dat (rd_dat)
    );

    assign pad = {2'b00, cnt} < {3'b000, pre};

    always_comb begin
        rd_addr = MSG_BASE;
        case (state)
            LD_PRE:  rd_addr = PRE_ADDR;
            LD_TAP:  rd_addr = TAP_ADDR;
            LD_SEED: rd_addr = SEED_ADDR;
            ENC:     if (!pad) rd_addr = MSG_BASE + ({2'b00, cnt} - {3'b000, pre});
            default: rd_addr = MSG_BASE;
        endcase
    end

    // Plaintext bit 7 is dropped; output bit 7 carries parity of the cipher bits.
    assign plain   = pad ? 8'h20 : rd_dat;
    assign enc7    = plain[6:0] ^ lfsr;
    assign wr_dat  = {^enc7, enc7};
    assign wr_addr = OUT_BASE + {2'b00, cnt};
    assign wr_vld  = (state == ENC);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            Ack   <= 1'b0;
            cnt   <= '0;
            lfsr  <= '0;
            taps  <= '0;
            pre   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Ack <= 1'b0;
                    if (!Start)
                        state <= LD_PRE;
                end
                LD_PRE: begin
                    pre   <= clamp_pre(rd_dat);
                    state <= LD_TAP;
                end
                LD_TAP: begin
                    taps  <= TAP_PATTERNS[tap_index(rd_dat)];
                    state <= LD_SEED;
                end
                LD_SEED: begin
                    lfsr  <= rd_dat[6:0];
                    cnt   <= '0;
                    state <= ENC;
                end
                ENC: begin
                    lfsr <= {lfsr[5:0], ^(lfsr & taps)};
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd63)
                        state <= DONE;
                end
                DONE: begin
                    // Ack is registered one edge after entering DONE, after the last write.
                    if (Start) begin
                        Ack   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Ack <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Randomised scoreboard bench for top_level: a reference model queues expected
// memory writes, a monitor pops and compares them as the engine writes.
module tb_top_level;
    import top_level_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b1;
    logic Ack;

    top_level dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Ack  (Ack)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int addr;
        int dat;
    } wr_t;

    wr_t        exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] img     [0:255];
    logic [7:0] exp_out [0:63];
    int         tap_tbl [0:8] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin : monitor
        wr_t e;
        if (Reset === 1'b0 && dut.DM.wr_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_write: write to 0x%0h with no write expected", dut.DM.wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {24'b0, dut.DM.wr_addr}, e.addr);
                check("wr_dat",  {24'b0, dut.DM.wr_dat},  e.dat);
            end
        end
    end

    task automatic load(input logic [7:0] seed, input logic [7:0] pt, input logic [7:0] pre_raw,
                        input int kind);
        string txt;
        txt = " 0123456789abcdefghijklmnopqrstuvwxyz. ";
        for (int i = 0; i < 61; i++) begin
            case (kind)
                0:       img[i] = 8'h20;
                1:       img[i] = (i < txt.len()) ? 8'(txt[i]) : 8'h20;
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
        img[61] = pre_raw;
        img[62] = pt;
        img[63] = seed;
        for (int i = 64; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) dut.DM.Core[i] = img[i];
    endtask

    task automatic compute_model();
        int pre, idx, taps, s, p, v, fb;
        wr_t w;
        pre = int'(img[61]);
        if (pre < 10) pre = 10;
        else if (pre > 26) pre = 26;
        idx  = (img[62] == 8'd8) ? 8 : int'(img[62]) % 8;
        taps = tap_tbl[idx];
        s    = int'(img[63]) & 127;
        for (int i = 0; i < 64; i++) begin
            p = (i < pre) ? 32 : int'(img[i - pre]);
            v = (p ^ s) & 127;
            exp_out[i] = 8'(v | (($countones(v) & 1) << 7));
            w.addr = 64 + i;
            w.dat  = int'(exp_out[i]);
            exp_q.push_back(w);
            fb = $countones(s & taps) & 1;
            s  = ((s << 1) | fb) & 127;
        end
    endtask

    task automatic run(input string name);
        int n;
        int score;
        compute_model();
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        for (n = 1; n <= 100; n++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) break;
        end
        check({name, "_ack_latency"}, n, 68);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
        score = 0;
        for (int i = 0; i < 64; i++)
            if (dut.DM.Core[64 + i] === exp_out[i]) score++;
        check({name, "_out_score"}, score, 64);
        score = 0;
        for (int i = 0; i < 64; i++)
            if (dut.DM.Core[i] === img[i]) score++;
        for (int i = 128; i < 256; i++)
            if (dut.DM.Core[i] === img[i]) score++;
        check({name, "_untouched_bytes"}, score, 192);
    endtask

    task automatic finish_done(input string name);
        repeat (3) @(posedge Clk);
        #1;
        check({name, "_ack_held"}, Ack, 1);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check({name, "_ack_drop"}, Ack, 0);
        check({name, "_idle"}, int'(dut.state), int'(IDLE));
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_ack", Ack, 0);
        check("reset_state", int'(dut.state), int'(IDLE));
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("idle_hold_ack", Ack, 0);
        check("idle_hold_state", int'(dut.state), int'(IDLE));

        load(8'h01, 8'h00, 8'd10, 0);
        run("seed01");
        check("seed01_dm64", dut.DM.Core[64], 8'h21);
        check("seed01_dm65", dut.DM.Core[65], 8'h22);
        finish_done("seed01");

        load(8'h7F, 8'h00, 8'd10, 0);
        run("seed7f");
        check("seed7f_dm64", dut.DM.Core[64], 8'h5F);
        check("seed7f_dm65", dut.DM.Core[65], 8'hDE);
        finish_done("seed7f");

        load(8'($urandom_range(1, 127)), 8'h33, 8'd5, 2);
        run("pre_low");
        finish_done("pre_low");

        load(8'($urandom_range(1, 127)), 8'h11, 8'd200, 2);
        run("pre_high");
        finish_done("pre_high");

        load(8'($urandom_range(1, 255)), 8'h08, 8'($urandom_range(0, 255)), 1);
        run("pt08");
        finish_done("pt08");

        load(8'($urandom_range(1, 255)), 8'h0D, 8'($urandom_range(0, 255)), 1);
        run("pt0d");
        finish_done("pt0d");

        load(8'($urandom_range(1, 255)), 8'hF8, 8'($urandom_range(0, 255)), 1);
        run("ptf8");
        finish_done("ptf8");

        load(8'h80, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
        run("seed_zero");
        finish_done("seed_zero");

        for (int r = 0; r < 4; r++) begin
            load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), (r % 2 == 0) ? 1 : 2);
            run("random");
            finish_done("random");
        end

        load(8'($urandom_range(1, 127)), 8'($urandom_range(0, 255)), 8'd12, 1);
        compute_model();
        @(negedge Clk);
        Start = 1'b0;
        repeat (30) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("midrun_reset_ack", Ack, 0);
        check("midrun_reset_state", int'(dut.state), int'(IDLE));
        check("midrun_reset_lfsr", {25'b0, dut.lfsr}, 0);
        check("midrun_partial_kept", dut.DM.Core[64], exp_out[0]);
        exp_q.delete();
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        load(8'($urandom_range(1, 127)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
        run("after_reset");
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("done_reset_ack", Ack, 0);
        check("done_reset_state", int'(dut.state), int'(IDLE));
        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("post_reset_idle", int'(dut.state), int'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/top_level.md
# top_level

Hardwired message-encryption engine with an embedded 256×8 data memory.
- On a Start handshake it reads a message, preamble length, LFSR pattern select and LFSR seed from fixed memory locations.
- It writes a 64-byte encrypted, parity-tagged stream back to memory, then raises Ack.
- It is the top of the Program-1 datapath; the bench loads and inspects memory hierarchically through instance `DM`, array `Core`.

## Interface
- No parameters.
- Clk  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  request; high holds the engine idle, low launches or permits a run.
- Ack  out  1  run complete; reset value 0.

## Operation
- Memory map:
  - DM[0..60] message, space-padded (0x20).
  - DM[61] raw preamble length.
  - DM[62] raw pattern select `pt_no`.
  - DM[63] seed; bits [6:0] used, bit 7 ignored.
  - DM[64..127] output.
  - DM[128..255] reserved; never read or written by the engine.
- Preamble `pre` = DM[61] clamped (unsigned): <10 → 10, >26 → 26, else unchanged.
- Tap index = 8 if `pt_no` == 8, else `pt_no`[2:0].
- Tap patterns, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR (7-bit):
  - s0 = seed.
  - s(k+1) = {s(k)[5:0], ^(s(k) & taps)}.
  - A zero seed is used as-is and gives an all-zero stream; the engine does not reject it.
- Padded character p(i), i = 0..63:
  - i < pre → 0x20.
  - else → DM[i − pre]; index ≤ 53 since pre ≥ 10.
- Output byte o(i):
  - o[6:0] = p(i)[6:0] ^ s(i).
  - o[7] = ^o[6:0]; p bit 7 is discarded.
  - Written to DM[64+i].
- FSM states: IDLE, LD_PRE, LD_TAP, LD_SEED, ENC, DONE.
  - IDLE: Ack=0. Start=0 → LD_PRE; Start=1 → stay.
  - LD_PRE / LD_TAP / LD_SEED: read DM[61] / DM[62] / DM[63] into registers, one cycle each; clamp and decode on capture.
  - ENC: counter i = 0..63. Each cycle writes o(i) to DM[64+i] and advances the LFSR; after i = 63 → DONE.
  - DONE: Ack=1. Start=1 → IDLE (Ack drops next edge); Start=0 → stay, no rerun.
- Start is ignored in LD_* and ENC.
- Reset, including mid-run:
  - FSM → IDLE, Ack=0, counter/LFSR/registers cleared.
  - Memory contents are not cleared; partial output remains.

## Timing
- Memory: combinational read, synchronous write, one read port and one write port; not reset.
- Inputs at DM[61..63] and the message must be stable before the first LD_PRE edge.
- Latency: Start low sampled in IDLE → Ack high 68 rising edges later (3 load + 64 encrypt + 1 into DONE).
- Ack is registered and never asserted before all 64 writes have committed.
- Output byte i is visible in DM[64+i] after the edge ending ENC cycle i.

## Structure
- Shared package: state enum, tap-pattern constant array (9×7 bits), address constants (MSG_BASE=0, PRE_ADDR=61, TAP_ADDR=62, SEED_ADDR=63, OUT_BASE=64), clamp bounds 10/26.
- Sub-module `data_mem`, instantiated as `DM`, storage array `Core[0:255]` of 8 bits. The bench preloads and reads it directly.
- The FSM, LFSR, counter and parity logic live in top_level.

## Test plan
- Seed 0x01, pt_no 0 (taps 0x60), DM[61]=10, all-space message → DM[64]=0x21, DM[65]=0x22; Ack high 68 cycles after Start low.
- Seed 0x7F, taps 0x60 → DM[64]=0x5F, DM[65]=0xDE (parity set).
- Clamp: DM[61]=5 behaves as pre=10; DM[61]=200 behaves as pre=26 (first message char lands at DM[90]).
- Pattern decode: pt_no=8 → taps 0x7B; pt_no=0x0D → index 5 (0x69); pt_no=0xF8 → index 0 (0x60). Compare all 64 bytes with a model; score must be 64/64.
- Message " 0123…xyz. " with random seed/pattern/pre → all 64 bytes match the model; DM[128..135] unchanged.
- Reset asserted mid-ENC → Ack=0 immediately, FSM idle. A new Start-high then Start-low handshake gives a full correct run. Start high while in DONE drops Ack the next cycle.
